spi_slave_tx: RTL and testbench
===============================

Name: spi_slave_tx

Overview:
Transmit half of the SPI slave datapath. Takes parallel words from the slave core through a valid/ready handshake and shifts them out MSB-first on sdo0 (single-line mode) or on sdo3..sdo0 (quad mode, one nibble per sclk cycle).
- Word length is cycle-count based, using the same counter_in/counter_in_upd convention as the slave receive path.
- A one-entry holding buffer allows back-to-back words with no idle cycle between them.

Parameters:
- DATA_WIDTH, 32, width of the parallel word. Must be ≥8 and a multiple of 4.

Ports:
- sclk  input  1  SPI clock; the only clock; all state updates on its rising edge
- cs  input  1  chip-select used as reset; synchronous, active-high, sampled on sclk rising edge
- en_quad_in  input  1  1 = quad mode (4 bits/cycle), 0 = single-line mode (1 bit/cycle)
- counter_in  input  8  word length in cycles minus 1 (bits-1 in single mode, nibbles-1 in quad mode)
- counter_in_upd  input  1  single-cycle strobe; loads counter_in as the new target
- data  input  DATA_WIDTH  word to send, left-aligned (first bit sent is data[DATA_WIDTH-1])
- data_valid  input  1  data is valid
- data_ready  output  1  holding buffer empty; a transfer occurs when data_valid && data_ready
- sdo0  output  1  serial data out / quad bit 0
- sdo1  output  1  quad bit 1 (0 in single mode)
- sdo2  output  1  quad bit 2 (0 in single mode)
- sdo3  output  1  quad bit 3 (0 in single mode)
- tx_done  output  1  high during the cycle the last bit or nibble of a word is on sdo

Behaviour:
- Reset (cs=1 at rising edge): state=TX_IDLE; hold_valid=0; sreg=0; counter=0; counter_trgt=8'h7; cur_trgt=8'h7; quad_q=0.
  - Resulting outputs: sdo0..3=0, data_ready=1, tx_done=0. Any word in flight or in the buffer is discarded.
- Target register:
  - counter_in_upd=1 sets counter_trgt<=counter_in.
  - Otherwise counter_trgt holds its value. There is no auto-change after the first word.
- Holding buffer:
  - data_ready = !hold_valid.
  - On a handshake, hold_data<=data and hold_valid<=1.
  - hold_valid clears when the word moves into sreg.
  - A handshake and a move in the same cycle are legal. The buffer stays full with the new word.
- Load event (move hold into sreg): occurs when hold_valid && (state==TX_IDLE || last-cycle condition). Effects:
  - sreg<=hold_data; counter<=0; state<=TX_SHIFT.
  - quad_q<=en_quad_in.
  - cur_trgt<=counter_trgt, except that if counter_in_upd is asserted the same cycle, counter_in is used.
- Word in flight: en_quad_in and counter_in_upd changes have no effect on it. They apply from the next load.
- TX_SHIFT, each cycle:
  - Outputs: single mode drives sdo0=sreg[DATA_WIDTH-1]. Quad mode drives {sdo3,sdo2,sdo1,sdo0}=sreg[DATA_WIDTH-1 -: 4].
  - If counter != cur_trgt: sreg shifts left by 1 (single) or 4 (quad), zero fill; counter<=counter+1.
  - If counter == cur_trgt (last cycle): tx_done=1. Then load next word if hold_valid (no gap), else state<=TX_IDLE.
- TX_IDLE: sdo0..3=0, tx_done=0, sreg and counter hold.
- Latency: a handshake at edge N puts the first bit on sdo after edge N+1, if idle.
- Word length: (cur_trgt+1) bits in single mode, 4*(cur_trgt+1) bits in quad mode.
  - If this exceeds DATA_WIDTH, the excess cycles shift out zeros. This is not an error.
- counter is 8-bit. cur_trgt=255 gives 256 cycles; the counter never wraps because it resets on match.
- Underrun: last cycle with the buffer empty returns to TX_IDLE. Outputs go to 0 the next cycle. No flag is raised.

Decomposition:
- Shared package spi_slave_pkg holds:
  - localparam SPI_TRGT_RST = 8'h7
  - typedef enum logic {TX_IDLE, TX_SHIFT} spi_tx_state_e
- Sub-module spi_slave_tx_hold: the one-entry buffer (data/valid/ready, pop input). spi_slave_tx contains the shifter, counters and FSM.

Test Plan:
- Reset: hold cs=1 for 2 cycles with data_valid=1 -> data_ready=1, sdo0..3=0, tx_done=0; the offered word is not transmitted after cs falls.
- Single-line default: after reset, data=32'hA5000000 with 1-cycle valid -> from the 2nd cycle, sdo0 = 1,0,1,0,0,1,0,1; tx_done on the 8th bit; then sdo0=0 and idle.
- Quad: counter_in=7 with upd, en_quad_in=1, data=32'h12345678 -> {sdo3..0} = 1,2,3,4,5,6,7,8 over 8 cycles; tx_done on the nibble 8 cycle.
- Back-to-back: trgt=7 single mode, words 32'hFF000000 then 32'h00000000 (second offered during the first) -> 16 contiguous bits (8 ones, 8 zeros); tx_done at bits 8 and 16; data_ready=0 while the buffer is full.
- Target change mid-word: upd counter_in=3 during bit 3 of an 8-bit word -> current word still 8 bits; the next word (32'hC0000000) sends 1,1,0,0 and tx_done on its 4th bit.
- Reset mid-word: cs=1 at bit 3 of a word with a second word buffered -> next cycle idle, sdo=0, buffer empty; a fresh word afterwards starts from its MSB.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave datapath.
package spi_slave_pkg;

    // Word-length target applied after chip-select reset (8 cycles).
    localparam logic [7:0] SPI_TRGT_RST = 8'h07;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } spi_tx_state_e;

endpackage

// File: rtl/spi_slave_tx_hold.sv
// One-entry holding buffer between the slave core and the transmit shifter.
module spi_slave_tx_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [DATA_WIDTH-1:0] hold_data_d;
    logic                  hold_valid_q;
    logic                  hold_valid_d;
    logic                  push_s;

    assign push_s  = valid_i && !hold_valid_q;
    assign ready_o = !hold_valid_q;
    assign data_o  = hold_data_q;
    assign valid_o = hold_valid_q;

    // Next-state: a push wins over a pop so a same-cycle refill keeps the buffer full.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        if (push_s) begin
            hold_data_d  = data_i;
            hold_valid_d = 1'b1;
        end else if (pop_i) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // Buffer registers, cleared by chip-select.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            hold_data_q  <= {DATA_WIDTH{1'b0}};
            hold_valid_q <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmit path: buffered parallel words shifted out MSB-first,
// one bit per sclk (single mode) or one nibble per sclk (quad mode).
module spi_slave_tx
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  en_quad_in,
    input  logic [7:0]            counter_in,
    input  logic                  counter_in_upd,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  sdo0,
    output logic                  sdo1,
    output logic                  sdo2,
    output logic                  sdo3,
    output logic                  tx_done
);

    spi_tx_state_e         state_q;
    spi_tx_state_e         state_d;
    logic [DATA_WIDTH-1:0] sreg_q;
    logic [DATA_WIDTH-1:0] sreg_d;
    logic [7:0]            counter_q;
    logic [7:0]            counter_d;
    logic [7:0]            counter_trgt_q;
    logic [7:0]            counter_trgt_d;
    logic [7:0]            cur_trgt_q;
    logic [7:0]            cur_trgt_d;
    logic                  quad_q;
    logic                  quad_d;

    logic [DATA_WIDTH-1:0] hold_data_s;
    logic                  hold_valid_s;
    logic                  pop_s;
    logic                  last_s;

    spi_slave_tx_hold #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold (
        .clk_i  (sclk),
        .srst_i (cs),
        .data_i (data),
        .valid_i(data_valid),
        .ready_o(data_ready),
        .pop_i  (pop_s),
        .data_o (hold_data_s),
        .valid_o(hold_valid_s)
    );

    // The last cycle of the word currently on the wire.
    assign last_s = (state_q == TX_SHIFT) && (counter_q == cur_trgt_q);

    // FSM next-state, shifter, counters and buffer pop.
    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        counter_d      = counter_q;
        cur_trgt_d     = cur_trgt_q;
        quad_d         = quad_q;
        pop_s          = 1'b0;
        counter_trgt_d = counter_in_upd ? counter_in : counter_trgt_q;

        case (state_q)
            TX_IDLE: begin
                if (hold_valid_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (last_s) begin
                    if (hold_valid_s) begin
                        pop_s = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    counter_d = counter_q + 8'd1;
                    if (quad_q) begin
                        sreg_d = {sreg_q[DATA_WIDTH-5:0], 4'b0000};
                    end else begin
                        sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Load: mode and length are latched here so a word in flight is never disturbed;
        // a same-cycle target strobe already applies to the word being loaded.
        if (pop_s) begin
            sreg_d     = hold_data_s;
            counter_d  = 8'd0;
            state_d    = TX_SHIFT;
            quad_d     = en_quad_in;
            cur_trgt_d = counter_in_upd ? counter_in : counter_trgt_q;
        end else begin
            cur_trgt_d = cur_trgt_q;
        end
    end

    // State registers, reset by chip-select.
    always_ff @(posedge sclk) begin
        if (cs) begin
            state_q        <= TX_IDLE;
            sreg_q         <= {DATA_WIDTH{1'b0}};
            counter_q      <= 8'd0;
            counter_trgt_q <= SPI_TRGT_RST;
            cur_trgt_q     <= SPI_TRGT_RST;
            quad_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            counter_q      <= counter_d;
            counter_trgt_q <= counter_trgt_d;
            cur_trgt_q     <= cur_trgt_d;
            quad_q         <= quad_d;
        end
    end

    // Output decode from registered state only; lines are quiet while idle.
    always_comb begin
        sdo0    = 1'b0;
        sdo1    = 1'b0;
        sdo2    = 1'b0;
        sdo3    = 1'b0;
        tx_done = last_s;
        if (state_q == TX_SHIFT) begin
            if (quad_q) begin
                {sdo3, sdo2, sdo1, sdo0} = sreg_q[DATA_WIDTH-1 -: 4];
            end else begin
                sdo0 = sreg_q[DATA_WIDTH-1];
            end
        end else begin
            sdo0 = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed, table-driven bench for spi_slave_tx.
module tb_spi_slave_tx;

    logic        sclk;
    logic        cs;
    logic        en_quad_in;
    logic [7:0]  counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic        tx_done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        cs;
        logic        quad;
        logic [7:0]  cnt;
        logic        upd;
        logic [31:0] data;
        logic        valid;
        logic        exp_ready;
        logic [3:0]  exp_sdo;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    spi_slave_tx #(.DATA_WIDTH(32)) dut (
        .sclk          (sclk),
        .cs            (cs),
        .en_quad_in    (en_quad_in),
        .counter_in    (counter_in),
        .counter_in_upd(counter_in_upd),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .sdo0          (sdo0),
        .sdo1          (sdo1),
        .sdo2          (sdo2),
        .sdo3          (sdo3),
        .tx_done       (tx_done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic add(input logic c, input logic q, input logic [7:0] n, input logic u,
                       input logic [31:0] d, input logic v,
                       input logic er, input logic [3:0] es, input logic ed);
        vec_t t;
        t.cs = c; t.quad = q; t.cnt = n; t.upd = u; t.data = d; t.valid = v;
        t.exp_ready = er; t.exp_sdo = es; t.exp_done = ed;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic c, input logic q, input logic [7:0] n, input logic u,
                         input logic [31:0] d, input logic v);
        cs = c; en_quad_in = q; counter_in = n; counter_in_upd = u; data = d; data_valid = v;
    endtask

    // One clock: inputs already applied, sample on the following falling edge.
    task automatic tick();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int idx, input logic er, input logic [3:0] es, input logic ed);
        check({name, ".ready"}, idx, {3'b000, data_ready}, {3'b000, er});
        check({name, ".sdo"},   idx, {sdo3, sdo2, sdo1, sdo0}, es);
        check({name, ".done"},  idx, {3'b000, tx_done}, {3'b000, ed});
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] w;

        drive(1'b1, 1'b0, 8'd0, 1'b0, 32'hA5000000, 1'b1);

        // Reset with an offered word, then idle: the word must be dropped.
        add(1'b1, 1'b0, 8'd0, 1'b0, 32'hA5000000, 1'b1, 1'b1, 4'h0, 1'b0);
        add(1'b1, 1'b0, 8'd0, 1'b0, 32'hA5000000, 1'b1, 1'b1, 4'h0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 4'h0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 4'h0, 1'b0);

        // Single-line, default 8-bit length.
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'hA5000000, 1'b1, 1'b0, 4'h0, 1'b0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, {3'b000, pat[7-i]}, (i == 7));
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);

        // Quad mode, 8 nibbles.
        add(1'b0, 1'b1, 8'd7, 1'b1, 32'h12345678, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b1, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'(i + 1), (i == 7));
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);

        // Back-to-back: 8 ones then 8 zeros with no gap.
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'hFF000000, 1'b1, 1'b0, 4'h0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b1, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4'h1, 1'b0);
        for (int i = 2; i < 8; i++)
            add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h1, (i == 7));
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, (i == 7));
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);

        // Target changes to 4 while an 8-bit word is on the wire.
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'hF0000000, 1'b1, 1'b0, 4'h0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd3, 1'b1, 32'hC0000000, 1'b1, 1'b0, 4'h1, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, (i == 3));
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b1);
        add(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].cs, vecs[i].quad, vecs[i].cnt, vecs[i].upd, vecs[i].data, vecs[i].valid);
            tick();
            check_outs("table", i, vecs[i].exp_ready, vecs[i].exp_sdo, vecs[i].exp_done);
        end

        // Reset mid-word with a second word buffered; length 4 set beforehand
        // must revert to 8 after reset.
        drive(1'b0, 1'b0, 8'd3, 1'b1, 32'hFFFFFFFF, 1'b1); tick();
        check_outs("rst_mid.offer", 0, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0); tick();
        check_outs("rst_mid.bit1", 1, 1'b1, 4'h1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 32'hAAAAAAAA, 1'b1); tick();
        check_outs("rst_mid.bit2", 2, 1'b0, 4'h1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0); tick();
        check_outs("rst_mid.bit3", 3, 1'b0, 4'h1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0); tick();
        check_outs("rst_mid.reset", 4, 1'b1, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0); tick();
        check_outs("rst_mid.idle", 5, 1'b1, 4'h0, 1'b0);
        tick();
        check_outs("rst_mid.idle2", 6, 1'b1, 4'h0, 1'b0);
        w = 32'h80000000;
        drive(1'b0, 1'b0, 8'd0, 1'b0, w, 1'b1); tick();
        check_outs("rst_mid.fresh_offer", 7, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_outs("rst_mid.fresh", 8 + i, 1'b1, {3'b000, w[31-i]}, (i == 7));
        end
        tick();
        check_outs("rst_mid.end", 16, 1'b1, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
